// File: rtl/board_io_hub_if.sv
// ---------------------------------------------------------------------------
// board_io_hub_if
//   CPU-side I/O port bus of the board I/O hub.
//
//   Signals:
//     io_sel   - channel select (inputs for reads, LED banks for writes)
//     io_wr    - output-port write request
//     io_wdata - data written to the selected LED bank
//     io_rdata - debounced value of the selected switch bank
//
//   Modports:
//     master - CPU side (drives select/write, reads io_rdata)
//     slave  - hub side (board_io_hub)
// ---------------------------------------------------------------------------
interface board_io_hub_if #(
    parameter int IO_W  = 4,
    parameter int SEL_W = 2
);
    logic [SEL_W-1:0] io_sel;
    logic             io_wr;
    logic [IO_W-1:0]  io_wdata;
    logic [IO_W-1:0]  io_rdata;

    modport master (
        output io_sel,
        output io_wr,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_sel,
        input  io_wr,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/board_io_hub.sv
// ---------------------------------------------------------------------------
// board_io_hub
//   Board-level I/O and clocking hub for a TD4-class CPU system.
//   - N_IN switch banks of IO_W bits: 2-FF synchronised, then debounced per
//     bank; the CPU reads the debounced bank chosen by io_sel.
//   - N_OUT LED banks of IO_W bits: latched from io_wdata when the CPU writes
//     on a cycle where it is enabled (cpu_ce high).
//   - CPU clock-enable generator: halt, free-run every DIV cycles, or one
//     pulse per step-button press; step_count counts every cpu_ce pulse.
//
//   Ports:
//     clock      - system clock, all state on rising edge
//     reset      - asynchronous active-low reset
//     mode       - 00 halt, 01 run, 10 step, 11 halt
//     step_btn   - raw step push-button
//     switch     - raw switch banks, bank i at [i*IO_W +: IO_W]
//     cpu_io     - CPU I/O bus (io_sel, io_wr, io_wdata, io_rdata)
//     led        - latched LED banks, same layout as switch
//     cpu_ce     - registered one-cycle CPU clock-enable
//     step_count - number of cpu_ce pulses since reset (wraps)
// ---------------------------------------------------------------------------
module board_io_hub #(
    parameter int IO_W         = 4,
    parameter int N_IN         = 2,
    parameter int N_OUT        = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int DIV          = 4,
    parameter int SEL_W        = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  step_btn,
    input  logic [N_IN*IO_W-1:0]  switch,
    board_io_hub_if.slave         cpu_io,
    output logic [N_OUT*IO_W-1:0] led,
    output logic                  cpu_ce,
    output logic [15:0]           step_count
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [1:0]       MODE_RUN  = 2'b01;
    localparam logic [1:0]       MODE_STEP = 2'b10;

    // Switch path state
    logic [N_IN*IO_W-1:0]          sw_meta_q, sw_meta_d;
    logic [N_IN*IO_W-1:0]          sw_sync_q, sw_sync_d;
    logic [N_IN-1:0][IO_W-1:0]     deb_q,     deb_d;
    logic [N_IN-1:0][CNT_W-1:0]    cnt_q,     cnt_d;

    // Step button path state
    logic                          btn_meta_q, btn_meta_d;
    logic                          btn_sync_q, btn_sync_d;
    logic                          btn_prev_q, btn_prev_d;

    // Clock-enable generator and output state
    logic [DIV_W-1:0]              div_q,   div_d;
    logic                          ce_q,    ce_d;
    logic [15:0]                   count_q, count_d;
    logic [N_OUT-1:0][IO_W-1:0]    led_q,   led_d;

    logic                          run_mode;
    logic                          step_mode;
    logic [IO_W-1:0]               rdata;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        run_mode   = (mode == MODE_RUN);
        step_mode  = (mode == MODE_STEP);

        sw_meta_d  = switch;
        sw_sync_d  = sw_meta_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;

        btn_meta_d = step_btn;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;

        div_d      = '0;
        ce_d       = 1'b0;
        count_d    = count_q + {15'd0, ce_q};
        led_d      = led_q;

        // Debounce: the counter measures how long the synced bank has
        // differed from the accepted value; any match restarts it.
        for (int i = 0; i < N_IN; i++) begin
            if (sw_sync_q[i*IO_W +: IO_W] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sw_sync_q[i*IO_W +: IO_W];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        // Divider only advances in run mode, so leaving run parks it at 0
        // and re-entering run always waits a full DIV period.
        if (run_mode && (div_q != DIV_LAST)) begin
            div_d = div_q + 1'b1;
        end

        // Edge detector runs in every mode; only step mode turns an edge
        // into a pulse, so presses in other modes are simply dropped.
        ce_d = (run_mode && (div_q == DIV_LAST)) ||
               (step_mode && btn_sync_q && !btn_prev_q);

        // A write only lands on the cycle the CPU is actually enabled.
        if (cpu_io.io_wr && ce_q) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (cpu_io.io_sel == SEL_W'(j)) begin
                    led_d[j] = cpu_io.io_wdata;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            deb_q      <= '0;
            cnt_q      <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            div_q      <= '0;
            ce_q       <= 1'b0;
            count_q    <= '0;
            led_q      <= '0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
            div_q      <= div_d;
            ce_q       <= ce_d;
            count_q    <= count_d;
            led_q      <= led_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux: unselected or out-of-range channels read as zero
    // -----------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (cpu_io.io_sel == SEL_W'(i)) begin
                rdata = deb_q[i];
            end
        end
    end

    assign cpu_io.io_rdata = rdata;
    assign led             = led_q;
    assign cpu_ce          = ce_q;
    assign step_count      = count_q;

endmodule
